// File: rtl/h_arb_pkg.sv
// Shared types and widths for the H-function (SHAKE-256 Keccak) arbiter.
package h_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } h_state_e;

  localparam int KECCAK_W = 1600;
  localparam int RHO_W    = 512;
  localparam int LEVEL_W  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int GNT_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [GNT_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // cand[k] is the requester index k positions after the pointer.
  logic [GNT_W-1:0] cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = GNT_W'((int'(ptr) + gi) % NUM_REQ);
    end
  endgenerate

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    gnt_oh  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        gnt_idx = cand[k];
        gnt_any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = gnt_any && (int'(gnt_idx) == i);
    end
  end

endmodule

// File: rtl/h_keccak_arbiter.sv
// Shares one H-function Keccak datapath between NUM_REQ requesters with
// round-robin grant, one outstanding job, and a WAIT-state watchdog.
module h_keccak_arbiter
  import h_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 256,
  parameter int GNT_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*RHO_W-1:0]      req_rho,
  input  logic [NUM_REQ*KECCAK_W-1:0]   req_keccak_in,
  input  logic [NUM_REQ-1:0]            req_rho_en,
  input  logic [NUM_REQ*LEVEL_W-1:0]    req_level,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [KECCAK_W-1:0]           rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          h_start,
  output logic [RHO_W-1:0]              h_rho,
  output logic [KECCAK_W-1:0]           h_keccak_in,
  output logic                          h_rho_en,
  output logic [LEVEL_W-1:0]            h_level,
  output logic                          h_rst_n,
  input  logic                          h_done,
  input  logic [KECCAK_W-1:0]           h_keccak_out
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  h_state_e               state_q, state_d;
  logic [GNT_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GNT_W-1:0]       gnt_q, gnt_d;
  logic [RHO_W-1:0]       rho_q, rho_d;
  logic [KECCAK_W-1:0]    kin_q, kin_d;
  logic                   rho_en_q, rho_en_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic [KECCAK_W-1:0]    rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic [RHO_W-1:0]       rho_arr   [NUM_REQ];
  logic [KECCAK_W-1:0]    kin_arr   [NUM_REQ];
  logic [LEVEL_W-1:0]     level_arr [NUM_REQ];

  logic [NUM_REQ-1:0]     arb_oh;
  logic [GNT_W-1:0]       arb_idx;
  logic                   arb_any;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign rho_arr[gi]   = req_rho[RHO_W*gi +: RHO_W];
      assign kin_arr[gi]   = req_keccak_in[KECCAK_W*gi +: KECCAK_W];
      assign level_arr[gi] = req_level[LEVEL_W*gi +: LEVEL_W];
      assign rsp_valid[gi] = (state_q == ST_RESP) && (int'(gnt_q) == gi);
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    rho_d      = rho_q;
    kin_d      = kin_q;
    rho_en_d   = rho_en_q;
    level_d    = level_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wd_d       = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d    = arb_idx;
          rho_d    = rho_arr[arb_idx];
          kin_d    = kin_arr[arb_idx];
          rho_en_d = req_rho_en[arb_idx];
          level_d  = level_arr[arb_idx];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (h_done) begin
          rsp_data_d = h_keccak_out;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (wd_q == WD_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_RESP: begin
        // Only the granted requester's ready completes the handshake.
        if (rsp_ready[gnt_q]) begin
          rr_ptr_d = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      rho_q      <= '0;
      kin_q      <= '0;
      rho_en_q   <= 1'b0;
      level_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      rho_q      <= rho_d;
      kin_q      <= kin_d;
      rho_en_q   <= rho_en_d;
      level_q    <= level_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wd_q       <= wd_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE) ? arb_oh : '0;
  assign busy        = (state_q != ST_IDLE);
  assign h_start     = (state_q == ST_ISSUE);
  assign h_rho       = rho_q;
  assign h_keccak_in = kin_q;
  assign h_rho_en    = rho_en_q;
  assign h_level     = level_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign h_rst_n     = ~rst;

endmodule

// File: tb/tb_h_keccak_arbiter.sv
// Directed self-checking bench for h_keccak_arbiter with a simple datapath model.
module tb_h_keccak_arbiter;
  import h_arb_pkg::*;

  localparam int NREQ = 3;

  logic                       clk;
  logic                       rst;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*RHO_W-1:0]      req_rho;
  logic [NREQ*KECCAK_W-1:0]   req_keccak_in;
  logic [NREQ-1:0]            req_rho_en;
  logic [NREQ*LEVEL_W-1:0]    req_level;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready;
  logic [KECCAK_W-1:0]        rsp_data;
  logic                       rsp_err;
  logic                       busy;
  logic                       h_start;
  logic [RHO_W-1:0]           h_rho;
  logic [KECCAK_W-1:0]        h_keccak_in;
  logic                       h_rho_en;
  logic [LEVEL_W-1:0]         h_level;
  logic                       h_rst_n;
  logic                       h_done;
  logic [KECCAK_W-1:0]        h_keccak_out;

  int checks = 0;
  int failures = 0;

  h_keccak_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(256), .GNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rho(req_rho), .req_keccak_in(req_keccak_in),
    .req_rho_en(req_rho_en), .req_level(req_level),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .h_start(h_start), .h_rho(h_rho), .h_keccak_in(h_keccak_in),
    .h_rho_en(h_rho_en), .h_level(h_level), .h_rst_n(h_rst_n),
    .h_done(h_done), .h_keccak_out(h_keccak_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: output depends on the presented state and level.
  assign h_keccak_out = ~h_keccak_in ^ {50{32'h0DDC_0000 | {30'd0, h_level}}};

  function automatic logic [RHO_W-1:0] rho_of(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic logic [KECCAK_W-1:0] kin_of(input int i);
    logic [31:0] w;
    w = 32'hC3C3_0000 ^ (32'(i) << 8) ^ 32'(i * 7);
    return {50{w}};
  endfunction

  function automatic logic [1:0] lvl_of(input int i);
    logic [1:0] t [3];
    t = '{2'd2, 2'd1, 2'd3};
    return t[i];
  endfunction

  function automatic logic [KECCAK_W-1:0] exp_out(input int i);
    logic [31:0] w;
    w = 32'h0DDC_0000 | {30'd0, lvl_of(i)};
    return ~kin_of(i) ^ {50{w}};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; h_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_rho[RHO_W*i +: RHO_W] = rho_of(i);
      req_keccak_in[KECCAK_W*i +: KECCAK_W] = kin_of(i);
      req_level[LEVEL_W*i +: LEVEL_W] = lvl_of(i);
      req_rho_en[i] = (i == 0);
    end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready got %b exp 000", req_ready); end
    checks++; if (rsp_valid !== 3'b000) begin failures++; $display("FAIL reset_rsp_valid got %b exp 000", rsp_valid); end
    checks++; if (rsp_data !== '0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp got data_lo=%h err=%b exp 0/0", rsp_data[63:0], rsp_err); end
    checks++; if (h_start !== 1'b0 || h_rho_en !== 1'b0 || h_level !== 2'd0) begin failures++; $display("FAIL reset_h_ctrl got start=%b rho_en=%b level=%0d exp 0", h_start, h_rho_en, h_level); end
    checks++; if (h_rho !== '0 || h_keccak_in !== '0) begin failures++; $display("FAIL reset_h_data got rho_lo=%h kin_lo=%h exp 0", h_rho[63:0], h_keccak_in[63:0]); end
    checks++; if (h_rst_n !== 1'b0) begin failures++; $display("FAIL reset_h_rst_n got %b exp 0", h_rst_n); end
    rst = 1'b0;
    #1;
    checks++; if (h_rst_n !== 1'b1) begin failures++; $display("FAIL release_h_rst_n got %b exp 1", h_rst_n); end
    $display("txn reset done");
  endtask

  task automatic test_single();
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got %b exp 001", req_ready); end
    tick();
    req_valid = 3'b000;
    checks++; if (h_start !== 1'b1 || h_level !== 2'd2 || h_rho_en !== 1'b1) begin failures++; $display("FAIL single_issue got start=%b level=%0d rho_en=%b exp 1/2/1", h_start, h_level, h_rho_en); end
    checks++; if (h_rho !== rho_of(0) || h_keccak_in !== kin_of(0)) begin failures++; $display("FAIL single_payload got rho_lo=%h kin_lo=%h", h_rho[63:0], h_keccak_in[63:0]); end
    checks++; if (req_ready !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL single_busy got ready=%b busy=%b exp 000/1", req_ready, busy); end
    tick();
    checks++; if (h_start !== 1'b0) begin failures++; $display("FAIL single_start_pulse got %b exp 0", h_start); end
    repeat (23) tick();
    checks++; if (rsp_valid !== 3'b000) begin failures++; $display("FAIL single_early_rsp got %b exp 000", rsp_valid); end
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    checks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b0) begin failures++; $display("FAIL single_rsp got valid=%b err=%b exp 001/0", rsp_valid, rsp_err); end
    checks++; if (rsp_data !== exp_out(0)) begin failures++; $display("FAIL single_data got %h exp %h", rsp_data[63:0], exp_out(0)); end
    rsp_ready = 3'b001;
    tick();
    rsp_ready = 3'b000;
    checks++; if (rsp_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL single_done got valid=%b busy=%b exp 000/0", rsp_valid, busy); end
    $display("txn single req=0 level=2 done");
  endtask

  task automatic test_back_to_back();
    int order [4];
    int e;
    order = '{0, 1, 2, 0};
    rst = 1'b1; req_valid = 3'b111;
    tick();
    rst = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      e = order[n];
      checks++; if (req_ready !== 3'(1 << e)) begin failures++; $display("FAIL rr_grant%0d got %b exp %b", n, req_ready, 3'(1 << e)); end
      tick();
      checks++; if (h_keccak_in !== kin_of(e) || h_level !== lvl_of(e)) begin failures++; $display("FAIL rr_payload%0d got kin_lo=%h level=%0d", n, h_keccak_in[63:0], h_level); end
      h_done = 1'b1;
      tick();
      tick();
      h_done = 1'b0;
      checks++; if (rsp_valid !== 3'(1 << e)) begin failures++; $display("FAIL rr_rsp%0d got %b exp %b", n, rsp_valid, 3'(1 << e)); end
      checks++; if (rsp_data !== exp_out(e)) begin failures++; $display("FAIL rr_data%0d got %h exp %h", n, rsp_data[63:0], exp_out(e)); end
      rsp_ready = 3'(1 << e);
      tick();
      rsp_ready = 3'b000;
      $display("txn rr n=%0d req=%0d done", n, e);
    end
    req_valid = 3'b000;
  endtask

  task automatic test_backpressure();
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL bp_grant got %b exp 100", req_ready); end
    tick();
    req_valid = 3'b000;
    tick();
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    rsp_ready = 3'b011;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (rsp_valid !== 3'b100 || busy !== 1'b1 || h_start !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got valid=%b busy=%b start=%b", c, rsp_valid, busy, h_start); end
      checks++; if (rsp_data !== exp_out(2) || rsp_err !== 1'b0) begin failures++; $display("FAIL bp_data%0d got %h err=%b exp %h", c, rsp_data[63:0], rsp_err, exp_out(2)); end
    end
    rsp_ready = 3'b100;
    tick();
    rsp_ready = 3'b000;
    checks++; if (rsp_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got valid=%b busy=%b exp 000/0", rsp_valid, busy); end
    $display("txn backpressure req=2 done");
  endtask

  task automatic test_timeout();
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== 3'b000) begin failures++; $display("FAIL stray_done got busy=%b valid=%b exp 0/000", busy, rsp_valid); end
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL to_grant got %b exp 010", req_ready); end
    tick();
    req_valid = 3'b000;
    tick();
    repeat (255) tick();
    checks++; if (rsp_valid !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL to_early got valid=%b busy=%b exp 000/1", rsp_valid, busy); end
    tick();
    checks++; if (rsp_valid !== 3'b010 || rsp_err !== 1'b1) begin failures++; $display("FAIL to_rsp got valid=%b err=%b exp 010/1", rsp_valid, rsp_err); end
    checks++; if (rsp_data !== '0) begin failures++; $display("FAIL to_data got %h exp 0", rsp_data[63:0]); end
    rsp_ready = 3'b010;
    tick();
    rsp_ready = 3'b000;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_release got busy=%b exp 0", busy); end
    $display("txn timeout req=1 err=1");
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL rmw_grant got %b exp 100", req_ready); end
    tick();
    req_valid = 3'b000;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 3'b000 || h_start !== 1'b0) begin failures++; $display("FAIL rmw_state got busy=%b valid=%b start=%b", busy, rsp_valid, h_start); end
    checks++; if (rsp_err !== 1'b0 || h_level !== 2'd0 || h_keccak_in !== '0 || h_rho !== '0) begin failures++; $display("FAIL rmw_regs got err=%b level=%0d kin_lo=%h", rsp_err, h_level, h_keccak_in[63:0]); end
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    checks++; if (rsp_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL rmw_no_rsp got valid=%b busy=%b", rsp_valid, busy); end
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rmw_ptr got %b exp 001", req_ready); end
    tick();
    req_valid = 3'b000;
    tick();
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    checks++; if (rsp_valid !== 3'b001 || rsp_data !== exp_out(0)) begin failures++; $display("FAIL rmw_serve got valid=%b data=%h", rsp_valid, rsp_data[63:0]); end
    rsp_ready = 3'b001;
    tick();
    rsp_ready = 3'b000;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmw_end got busy=%b exp 0", busy); end
    $display("txn reset_mid_wait re-request req=0 done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
